axis_pattern_gen: RTL and testbench

- Single-clock AXI-Stream packet source that drives the input stream of the demo AXI-stream block (i_axis_in_*).
- Used for bring-up and throughput tests; emits framed packets with tuser on the first beat and tlast on the last beat.
- Run-level control: a start pulse, packet length, packet count and seed; one-cycle done pulse at the end.

---
 rtl/axis_pattern_gen_if.sv | 27 ++
 rtl/axis_pattern_gen.sv | 143 ++++++++++++++
 tb/tb_axis_pattern_gen.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pattern_gen_if.sv
// axis_pattern_gen_if: AXI-Stream bundle (tdata/tuser/tlast/tvalid/tready).
// master drives payload and valid and samples ready; slave is the mirror.
interface axis_pattern_gen_if #(
   parameter int AXIS_DATA_WIDTH = 32
);
   logic                       tuser;
   logic                       tvalid;
   logic                       tready;
   logic                       tlast;
   logic [AXIS_DATA_WIDTH-1:0] tdata;

   modport master (
      output tuser,
      output tvalid,
      output tlast,
      output tdata,
      input  tready
   );

   modport slave (
      input  tuser,
      input  tvalid,
      input  tlast,
      input  tdata,
      output tready
   );
endinterface

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: framed AXI-Stream packet source for bring-up/throughput.
// Ports: i_axis_clk, i_axis_rst (sync, active-low); run control i_start,
// i_abort, i_pkt_len, i_pkt_count, i_seed; status o_busy, o_done,
// o_pkt_sent; stream o_axis_out (master modport: tuser/tvalid/tlast/tdata,
// tready in). Macro AXIS_PATTERN_GEN_LFSR_EN: data advances as a 32-bit
// LFSR instead of +1 per transfer.
module axis_pattern_gen #(
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int GAP_CYCLES      = 0
) (
   input  logic                       i_axis_clk,
   input  logic                       i_axis_rst,
   input  logic                       i_start,
   input  logic                       i_abort,
   input  logic [LEN_WIDTH-1:0]       i_pkt_len,
   input  logic [LEN_WIDTH-1:0]       i_pkt_count,
   input  logic [AXIS_DATA_WIDTH-1:0] i_seed,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [LEN_WIDTH-1:0]       o_pkt_sent,
   axis_pattern_gen_if.master         o_axis_out
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST =
      GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [1:0]                 r_state;
   logic [LEN_WIDTH-1:0]       r_len;
   logic [LEN_WIDTH-1:0]       r_count;
   logic [LEN_WIDTH-1:0]       r_beat;
   logic [LEN_WIDTH-1:0]       r_sent;
   logic [AXIS_DATA_WIDTH-1:0] r_data;
   logic [GW-1:0]              r_gap;
   logic                       r_abort;

   logic                       w_send;
   logic                       w_xfer;
   logic                       w_first;
   logic                       w_last;
   logic                       w_run_end;
   logic [LEN_WIDTH-1:0]       w_sent_nxt;
   logic [AXIS_DATA_WIDTH-1:0] w_data_nxt;
   logic [AXIS_DATA_WIDTH-1:0] w_seed;

`ifdef AXIS_PATTERN_GEN_LFSR_EN
   if (AXIS_DATA_WIDTH != 32) begin : g_width_chk
      $error("axis_pattern_gen: LFSR data needs AXIS_DATA_WIDTH == 32");
   end

   // All-zero is the LFSR lock-up state, so it is never loaded.
   assign w_seed = (i_seed == '0) ? AXIS_DATA_WIDTH'(1) : i_seed;
   assign w_data_nxt = {r_data[30:0],
                        r_data[31] ^ r_data[21] ^ r_data[1] ^ r_data[0]};
`else
   assign w_seed     = i_seed;
   assign w_data_nxt = r_data + AXIS_DATA_WIDTH'(1);
`endif

   assign w_send     = (r_state == S_SEND);
   assign w_xfer     = w_send && o_axis_out.tready;
   assign w_first    = (r_beat == '0);
   assign w_last     = (r_beat == r_len - LEN_WIDTH'(1));
   assign w_sent_nxt = r_sent + LEN_WIDTH'(1);
   // Abort seen on the tlast cycle itself still ends the run here.
   assign w_run_end  = (w_sent_nxt == r_count) || r_abort || i_abort;

   assign o_axis_out.tvalid = w_send;
   assign o_axis_out.tuser  = w_send && w_first;
   assign o_axis_out.tlast  = w_send && w_last;
   assign o_axis_out.tdata  = r_data;
   assign o_busy            = (r_state != S_IDLE);
   assign o_done            = (r_state == S_DONE);
   assign o_pkt_sent        = r_sent;

   always_ff @(posedge i_axis_clk) begin
      if (!i_axis_rst) begin
         r_state <= S_IDLE;
         r_len   <= '0;
         r_count <= '0;
         r_beat  <= '0;
         r_sent  <= '0;
         r_data  <= '0;
         r_gap   <= '0;
         r_abort <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_abort <= 1'b0;
               if (i_start) begin
                  r_len   <= i_pkt_len;
                  r_count <= i_pkt_count;
                  r_data  <= w_seed;
                  r_beat  <= '0;
                  r_sent  <= '0;
                  if (i_pkt_len != '0 && i_pkt_count != '0) begin
                     r_state <= S_SEND;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_SEND: begin
               if (i_abort) begin
                  r_abort <= 1'b1;
               end
               if (w_xfer) begin
                  r_data <= w_data_nxt;
                  if (w_last) begin
                     r_beat <= '0;
                     r_sent <= w_sent_nxt;
                     if (w_run_end) begin
                        r_state <= S_DONE;
                     end else if (GAP_CYCLES > 0) begin
                        r_state <= S_GAP;
                        r_gap   <= '0;
                     end
                  end else begin
                     r_beat <= r_beat + LEN_WIDTH'(1);
                  end
               end
            end
            S_GAP: begin
               if (i_abort) begin
                  r_state <= S_DONE;
               end else if (r_gap == GAP_LAST) begin
                  r_state <= S_SEND;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb_axis_pattern_gen: scoreboard bench, two DUTs (GAP_CYCLES 0 and 3).
// Expected beats come from a packet-list model; negedge monitors compare.
module tb_axis_pattern_gen;
   localparam int DW     = 32;
   localparam int LW     = 16;
   localparam int BUDGET = 5000;

   typedef struct {
      logic [DW-1:0] d;
      logic          u;
      logic          l;
      int            gap;
   } beat_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    start = '0;
   logic [1:0]    abort = '0;
   logic [1:0]    rdy   = '0;
   logic [LW-1:0] len   = '0;
   logic [LW-1:0] cnt   = '0;
   logic [DW-1:0] seed  = '0;

   logic          busy [2];
   logic          done [2];
   logic [LW-1:0] sent [2];
   logic          tv   [2];
   logic          tu   [2];
   logic          tl   [2];
   logic [DW-1:0] td   [2];

   int checks = 0;
   int errors = 0;
   int mode     [2] = '{0, 0};
   int xfer_cnt [2] = '{0, 0};
   int done_cnt [2] = '{0, 0};
   beat_t exp_q      [2][$];
   int    exp_done_q [2][$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      axis_pattern_gen_if #(.AXIS_DATA_WIDTH(DW)) u_if ();

      logic          hold_v;
      logic [DW-1:0] hold_d;
      logic          hold_u;
      logic          hold_l;
      logic          prev_last;
      logic          prev_start;
      int            idle;
      int            n;
      beat_t         e;

      axis_pattern_gen #(
         .AXIS_DATA_WIDTH(DW),
         .LEN_WIDTH      (LW),
         .GAP_CYCLES     (3 * g)
      ) u_dut (
         .i_axis_clk (clk),
         .i_axis_rst (rst_n),
         .i_start    (start[g]),
         .i_abort    (abort[g]),
         .i_pkt_len  (len),
         .i_pkt_count(cnt),
         .i_seed     (seed),
         .o_busy     (busy[g]),
         .o_done     (done[g]),
         .o_pkt_sent (sent[g]),
         .o_axis_out (u_if)
      );

      assign u_if.tready = rdy[g];
      assign tv[g] = u_if.tvalid;
      assign tu[g] = u_if.tuser;
      assign tl[g] = u_if.tlast;
      assign td[g] = u_if.tdata;

      always @(negedge clk) begin
         if (!rst_n) begin
            hold_v     = 1'b0;
            prev_last  = 1'b0;
            prev_start = 1'b0;
            idle       = 0;
         end else begin
            if (hold_v) begin
               checks++;
               if (!(tv[g] && td[g] == hold_d && tu[g] == hold_u &&
                     tl[g] == hold_l)) begin
                  errors++;
                  $display("FAIL hold[%0d]: got v=%0b d=%h u=%0b l=%0b, want v=1 d=%h u=%0b l=%0b",
                           g, tv[g], td[g], tu[g], tl[g], hold_d, hold_u, hold_l);
               end
            end
            if (done[g]) begin
               checks++;
               if (exp_done_q[g].size() == 0) begin
                  errors++;
                  $display("FAIL done[%0d]: got unexpected done, want none", g);
               end else begin
                  n = exp_done_q[g].pop_front();
                  if (sent[g] != LW'(n) || !busy[g] || tv[g] ||
                      !(prev_last || prev_start)) begin
                     errors++;
                     $display("FAIL done[%0d]: got sent=%0d busy=%0b v=%0b after_last=%0b after_start=%0b, want sent=%0d busy=1 v=0 and one of them",
                              g, sent[g], busy[g], tv[g], prev_last, prev_start, n);
                  end
               end
               done_cnt[g]++;
            end
            prev_last = 1'b0;
            if (tv[g] && rdy[g]) begin
               checks++;
               if (exp_q[g].size() == 0) begin
                  errors++;
                  $display("FAIL beat[%0d]: got unexpected d=%h, want none", g, td[g]);
               end else begin
                  e = exp_q[g].pop_front();
                  if (td[g] != e.d || tu[g] != e.u || tl[g] != e.l ||
                      (e.gap >= 0 && idle != e.gap)) begin
                     errors++;
                     $display("FAIL beat[%0d]: got d=%h u=%0b l=%0b idle=%0d, want d=%h u=%0b l=%0b idle=%0d",
                              g, td[g], tu[g], tl[g], idle, e.d, e.u, e.l, e.gap);
                  end
               end
               prev_last = tl[g];
               idle = 0;
               xfer_cnt[g]++;
            end else if (!tv[g]) begin
               idle++;
            end
            hold_v     = tv[g] && !rdy[g];
            hold_d     = td[g];
            hold_u     = tu[g];
            hold_l     = tl[g];
            prev_start = start[g];
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int g = 0; g < 2; g++) begin
            case (mode[g])
               0:       rdy[g] = 1'b1;
               1:       rdy[g] = ~rdy[g];
               default: rdy[g] = 1'($urandom_range(0, 1));
            endcase
         end
      end
   end

   function automatic logic [DW-1:0] step(input logic [DW-1:0] d);
`ifdef AXIS_PATTERN_GEN_LFSR_EN
      return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
`else
      return d + 1;
`endif
   endfunction

   // Expected run: packet list built from len/count/abort, data stepping
   // once per beat across the whole run.
   function automatic int push_run(input int g, input logic [DW-1:0] s,
                                   input int l, input int c, input int ab);
      logic [DW-1:0] d;
      int            npk;
      beat_t         b;
      npk = (l == 0 || c == 0) ? 0 : c;
      if (ab >= 0 && l > 0 && npk > ab / l + 1) npk = ab / l + 1;
      d = s;
`ifdef AXIS_PATTERN_GEN_LFSR_EN
      if (d == '0) d = 1;
`endif
      for (int p = 0; p < npk; p++) begin
         for (int i = 0; i < l; i++) begin
            b.d   = d;
            b.u   = (i == 0);
            b.l   = (i == l - 1);
            b.gap = (i != 0) ? 0 : ((p == 0) ? -1 : 3 * g);
            exp_q[g].push_back(b);
            d = step(d);
         end
      end
      exp_done_q[g].push_back(npk);
      return npk;
   endfunction

   task automatic check_zero(input int g, input string tag);
      checks++;
      if (tv[g] || tu[g] || tl[g] || td[g] != '0 || busy[g] ||
          done[g] || sent[g] != '0) begin
         errors++;
         $display("FAIL %s[%0d]: got v=%0b u=%0b l=%0b d=%h busy=%0b done=%0b sent=%0d, want all 0",
                  tag, g, tv[g], tu[g], tl[g], td[g], busy[g], done[g], sent[g]);
      end
   endtask

   task automatic kick(input int g, input logic [DW-1:0] s,
                       input int l, input int c);
      @(posedge clk);
      #1;
      len      = LW'(l);
      cnt      = LW'(c);
      seed     = s;
      start[g] = 1'b1;
      @(posedge clk);
      #1;
      start[g] = 1'b0;
      len      = LW'($urandom);
      cnt      = LW'($urandom);
      seed     = $urandom;
      checks++;
      if (!busy[g]) begin
         errors++;
         $display("FAIL busy[%0d]: got 0 after start, want 1", g);
      end
   endtask

   task automatic run(input int g, input logic [DW-1:0] s, input int l,
                      input int c, input int m, input int ab, input int rs);
      int npk;
      int base;
      int dc;
      int k;
      npk     = push_run(g, s, l, c, ab);
      mode[g] = m;
      base    = xfer_cnt[g];
      dc      = done_cnt[g];
      kick(g, s, l, c);
      k = 0;
      while (done_cnt[g] == dc && k < BUDGET) begin
         abort[g] = (ab >= 0 && xfer_cnt[g] - base == ab);
         if (rs >= 0 && xfer_cnt[g] - base == rs) begin
            start[g] = 1'b1;
            len      = 3;
            cnt      = 1;
         end else begin
            start[g] = 1'b0;
         end
         @(posedge clk);
         #1;
         k++;
      end
      abort[g] = 1'b0;
      start[g] = 1'b0;
      checks++;
      if (k >= BUDGET) begin
         errors++;
         $display("FAIL timeout[%0d]: got no done in %0d cycles, want done", g, BUDGET);
      end
      checks++;
      if (busy[g] || done[g] || sent[g] != LW'(npk) || exp_q[g].size() != 0) begin
         errors++;
         $display("FAIL end[%0d]: got busy=%0b done=%0b sent=%0d left=%0d, want 0 0 %0d 0",
                  g, busy[g], done[g], sent[g], exp_q[g].size(), npk);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int k;
      int npk;

      repeat (3) @(posedge clk);
      #1;
      check_zero(0, "reset");
      check_zero(1, "reset");
      rst_n = 1'b1;

      run(0, 32'h10, 4, 2, 0, -1, -1);
      run(0, 32'h10, 4, 2, 1, -1, -1);
      run(1, 32'hFFFF_FFFF, 1, 3, 0, -1, -1);
      run(0, 32'h200, 8, 5, 0, 10, -1);
      run(0, 32'h33, 0, 3, 0, -1, -1);
      run(0, 32'h44, 5, 0, 0, -1, -1);
      run(1, 32'h55, 0, 2, 0, -1, -1);
      run(0, 32'h100, 8, 2, 1, -1, 3);

      @(posedge clk);
      #1;
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      abort[0] = 1'b0;
      run(0, 32'h77, 3, 2, 0, -1, -1);

`ifdef AXIS_PATTERN_GEN_LFSR_EN
      run(0, 32'h1, 4, 1, 0, -1, -1);
      run(0, 32'h0, 3, 2, 1, -1, -1);
`endif

      for (int i = 0; i < 12; i++) begin
         run(int'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
             2, -1, -1);
      end

      npk     = push_run(0, 32'hA5A5_0000, 6, 2, -1);
      mode[0] = 0;
      base    = xfer_cnt[0];
      kick(0, 32'hA5A5_0000, 6, 2);
      k = 0;
      while (xfer_cnt[0] - base < 3 && k < BUDGET) begin
         @(posedge clk);
         #1;
         k++;
      end
      checks++;
      if (k >= BUDGET || !tv[0]) begin
         errors++;
         $display("FAIL midpkt: got xfers=%0d v=%0b, want 3 and valid", xfer_cnt[0] - base, tv[0]);
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_zero(0, "midreset");
      exp_q[0].delete();
      exp_done_q[0].delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run(0, 32'h0BAD_F00D, 3, 1, 0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
